conv3x3_sched: RTL and testbench
================================

CONV3X3_SCHED -- requirements
Module: conv3x3_sched

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, giving the pixel/output memory address width.
REQ-002 The block SHALL have parameter DIM_W, default 8, giving the width of the image dimension registers.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: begins a frame when sampled high in IDLE.
REQ-006 The block SHALL have ports cfg_width and cfg_height, input, DIM_W bits: unsigned image width W and height H, latched at start.
REQ-007 The block SHALL have ports busy, done and cfg_err, output, 1 bit each: frame in progress, one-cycle end pulse, and invalid-dimension flag.
REQ-008 The block SHALL have ports pix_rd_en (output, 1), pix_rd_addr (output, ADDR_W) and pix_rd_data (input, 16): the Q8.8 pixel memory read port, with read latency 1 cycle.
REQ-009 The block SHALL have ports win_valid (output, 1) and win_data (output, 144): nine Q8.8 taps to the 3x3 MAC, tap k in bits [16k+15:16k], k = ky*3+kx.
REQ-010 The block SHALL have ports conv_data (input, 16) and conv_valid (input, 1): the MAC result, which arrives exactly 2 cycles after win_valid.
REQ-011 The block SHALL have ports out_wr_en (output, 1), out_wr_addr (output, ADDR_W) and out_wr_data (output, 16): the output memory write port.

Function
REQ-012 The FSM SHALL have states IDLE, FETCH, ISSUE, NEXT, DRAIN and DONE.
REQ-013 IDLE→FETCH on start, latching W and H and clearing row r, column c and out_addr to 0.
REQ-014 FETCH SHALL issue 9 reads, one per cycle, in ky-major order at addr = (r+ky)*W + (c+kx), then wait 1 cycle for the last data and go to ISSUE.
REQ-015 Read data SHALL be captured into tap k one cycle after the corresponding read; all taps SHALL be valid together when entering ISSUE.
REQ-016 ISSUE SHALL hold win_valid high for exactly 1 cycle with all taps stable, then go to NEXT.
REQ-017 NEXT: if c < W-3, increment c; else set c=0 and, if r < H-3, increment r; otherwise go to DRAIN. Each non-final case returns to FETCH.
REQ-018 FETCH of the next window SHALL overlap MAC latency; one window is issued per 12 cycles.
REQ-019 Each conv_valid SHALL produce out_wr_en=1 the same cycle, with out_wr_data=conv_data and out_wr_addr=out_addr; out_addr then increments.
REQ-020 DRAIN SHALL wait until in-flight count (issued minus written) is 0, then go to DONE.
REQ-021 DONE SHALL pulse done for 1 cycle and then go to IDLE; busy SHALL be high in every state except IDLE.
REQ-022 Total writes SHALL be (W-2)*(H-2), with no padding.
REQ-023 If W<3 or H<3 at start, the block SHALL make no reads or writes, set cfg_err=1, and go IDLE→DONE; cfg_err SHALL hold until the next start.
REQ-024 start while busy SHALL be ignored; cfg_* changes after start SHALL have no effect.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_W; (H*W) beyond range is a software error and needs no detection.
REQ-026 pix_rd_en, win_valid, out_wr_en and done SHALL be 0 whenever not asserted by the above rules.

Reset
REQ-027 On rst the block SHALL go to IDLE and clear all outputs, taps, counters and cfg_err to 0 at the next edge, including mid-frame; conv_valid arriving after reset SHALL be ignored.

Configuration
REQ-028 With CONV3X3_SCHED_RELU_EN defined, out_wr_data SHALL be 0 when conv_data is negative (bit 15 set), else conv_data; undefined, out_wr_data SHALL equal conv_data unmodified.

Structure
REQ-029 Package conv_pkg SHALL hold the FSM state typedef, DATA_W=16, KTAPS=9 and MAC_LAT=2.
REQ-030 Window address generation (r, c, ky, kx → address) SHALL be sub-module conv3x3_addr_gen.

Verification
REQ-031 Bench: 4x4 frame, pix[i]=i*0x0100, MAC model centre weight 0x0100 -> 4 writes: addr 0..3, data 0x0500, 0x0600, 0x0900, 0x0A00, then done.
REQ-032 Bench: first window of 5x3 frame -> pix_rd_addr sequence 0,1,2,5,6,7,10,11,12, and win_valid 1 cycle after last data.
REQ-033 Bench: cfg_width=2 -> cfg_err=1, done pulse, zero pix_rd_en and out_wr_en.
REQ-034 Bench: start pulsed mid-frame -> no restart, write count still (W-2)*(H-2).
REQ-035 Bench: rst during FETCH -> IDLE next cycle, outputs 0; a new start completes normally.
REQ-036 Bench: RELU_EN defined, conv_data=0xFF00 -> out_wr_data=0x0000; undefined -> 0xFF00.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window scheduler.
package conv_pkg;

    localparam int DATA_W  = 16;
    localparam int KTAPS   = 9;
    localparam int MAC_LAT = 2;

    // Wide enough to count every window that can be in flight inside the MAC.
    localparam int INFL_W  = $clog2(MAC_LAT + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        NEXT,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/conv3x3_addr_gen.sv
// Pixel address for tap (ky, kx) of the window anchored at row r, column c.
module conv3x3_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic [DIM_W-1:0]  row,
    input  logic [DIM_W-1:0]  col,
    input  logic [DIM_W-1:0]  width,
    input  logic [1:0]        ky,
    input  logic [1:0]        kx,
    output logic [ADDR_W-1:0] addr
);

    // All arithmetic is done at ADDR_W bits so it wraps modulo 2^ADDR_W.
    always_comb begin
        addr = (ADDR_W'(row) + ADDR_W'(ky)) * ADDR_W'(width)
             + ADDR_W'(col) + ADDR_W'(kx);
    end

endmodule

// File: rtl/conv3x3_sched.sv
// 3x3 sliding-window scheduler: fetches each window, issues it to an external MAC
// and writes the results. Define CONV3X3_SCHED_RELU_EN to clamp negative results to 0.
module conv3x3_sched
    import conv_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIM_W-1:0]        cfg_width,
    input  logic [DIM_W-1:0]        cfg_height,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic                    pix_rd_en,
    output logic [ADDR_W-1:0]       pix_rd_addr,
    input  logic [DATA_W-1:0]       pix_rd_data,
    output logic                    win_valid,
    output logic [KTAPS*DATA_W-1:0] win_data,
    input  logic [DATA_W-1:0]       conv_data,
    input  logic                    conv_valid,
    output logic                    out_wr_en,
    output logic [ADDR_W-1:0]       out_wr_addr,
    output logic [DATA_W-1:0]       out_wr_data
);

    localparam logic [DIM_W-1:0] MIN_DIM = DIM_W'(3);
    localparam logic [3:0]       LAST_K  = 4'(KTAPS);

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0]    r_q, r_d, c_q, c_d;
    logic [1:0]          ky_q, ky_d, kx_q, kx_d;
    logic [3:0]          kidx_q, kidx_d;
    logic                rd_vld_q, rd_vld_d;
    logic [3:0]          rd_tap_q, rd_tap_d;
    logic [DATA_W-1:0]   tap_q [KTAPS];
    logic [DATA_W-1:0]   tap_d [KTAPS];
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [INFL_W-1:0]   inflight_q, inflight_d;
    logic                cfg_err_q, cfg_err_d;
    logic [ADDR_W-1:0]   gen_addr;
    logic [DATA_W-1:0]   relu_data;

    conv3x3_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .row   (r_q),
        .col   (c_q),
        .width (w_q),
        .ky    (ky_q),
        .kx    (kx_q),
        .addr  (gen_addr)
    );

    always_comb begin
`ifdef CONV3X3_SCHED_RELU_EN
        relu_data = conv_data[DATA_W-1] ? '0 : conv_data;
`else
        relu_data = conv_data;
`endif
    end

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        r_d        = r_q;
        c_d        = c_q;
        ky_d       = ky_q;
        kx_d       = kx_q;
        kidx_d     = kidx_q;
        rd_vld_d   = 1'b0;
        rd_tap_d   = kidx_q;
        tap_d      = tap_q;
        out_addr_d = out_addr_q;
        cfg_err_d  = cfg_err_q;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        pix_rd_en  = 1'b0;
        win_valid  = 1'b0;

        // Read data lands one cycle after its request; rd_tap_q remembers which tap it feeds.
        if (rd_vld_q) begin
            tap_d[rd_tap_q] = pix_rd_data;
        end

        // A result with nothing in flight is stale (e.g. issued before a reset) and is dropped.
        out_wr_en = conv_valid && (inflight_q != '0);
        if (out_wr_en) begin
            out_addr_d = out_addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d        = cfg_width;
                    h_d        = cfg_height;
                    r_d        = '0;
                    c_d        = '0;
                    ky_d       = '0;
                    kx_d       = '0;
                    kidx_d     = '0;
                    out_addr_d = '0;
                    if ((cfg_width < MIN_DIM) || (cfg_height < MIN_DIM)) begin
                        cfg_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cfg_err_d = 1'b0;
                        state_d   = FETCH;
                    end
                end
            end
            FETCH: begin
                if (kidx_q < LAST_K) begin
                    pix_rd_en = 1'b1;
                    rd_vld_d  = 1'b1;
                    kidx_d    = kidx_q + 4'd1;
                    if (kx_q == 2'd2) begin
                        kx_d = 2'd0;
                        ky_d = ky_q + 2'd1;
                    end else begin
                        kx_d = kx_q + 2'd1;
                    end
                end else begin
                    kidx_d  = '0;
                    ky_d    = '0;
                    kx_d    = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                win_valid = 1'b1;
                state_d   = NEXT;
            end
            NEXT: begin
                if (c_q < (w_q - MIN_DIM)) begin
                    c_d     = c_q + DIM_W'(1);
                    state_d = FETCH;
                end else begin
                    c_d = '0;
                    if (r_q < (h_q - MIN_DIM)) begin
                        r_d     = r_q + DIM_W'(1);
                        state_d = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inflight_d = inflight_q + INFL_W'(win_valid) - INFL_W'(out_wr_en);
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < KTAPS; k++) begin
            win_data[k*DATA_W +: DATA_W] = tap_q[k];
        end
    end

    assign pix_rd_addr = pix_rd_en ? gen_addr : '0;
    assign out_wr_addr = out_addr_q;
    assign out_wr_data = out_wr_en ? relu_data : '0;
    assign cfg_err     = cfg_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            w_q        <= '0;
            h_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            kidx_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_tap_q   <= '0;
            tap_q      <= '{default: '0};
            out_addr_q <= '0;
            inflight_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            r_q        <= r_d;
            c_q        <= c_d;
            ky_q       <= ky_d;
            kx_q       <= kx_d;
            kidx_q     <= kidx_d;
            rd_vld_q   <= rd_vld_d;
            rd_tap_q   <= rd_tap_d;
            tap_q      <= tap_d;
            out_addr_q <= out_addr_d;
            inflight_q <= inflight_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_conv3x3_sched.sv
// Self-checking bench for conv3x3_sched: pixel memory, 2-cycle MAC model and a frame-level reference.
module tb_conv3x3_sched;

    localparam int ADDR_W = 16;
    localparam int DIM_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DIM_W-1:0]  cfg_width, cfg_height;
    logic              busy, done, cfg_err;
    logic              pix_rd_en;
    logic [ADDR_W-1:0] pix_rd_addr;
    logic [15:0]       pix_rd_data;
    logic              win_valid;
    logic [143:0]      win_data;
    logic [15:0]       conv_data;
    logic              conv_valid;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic [15:0]       out_wr_data;

    always #5 clk = ~clk;

    conv3x3_sched #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .pix_rd_en   (pix_rd_en),
        .pix_rd_addr (pix_rd_addr),
        .pix_rd_data (pix_rd_data),
        .win_valid   (win_valid),
        .win_data    (win_data),
        .conv_data   (conv_data),
        .conv_valid  (conv_valid),
        .out_wr_en   (out_wr_en),
        .out_wr_addr (out_wr_addr),
        .out_wr_data (out_wr_data)
    );

    // Pixel memory with one cycle of read latency.
    logic [15:0] pix_mem [0:1023];
    always @(posedge clk) begin
        if (pix_rd_en) pix_rd_data <= pix_mem[pix_rd_addr[9:0]];
    end

    // MAC model: Q8.8 weighted sum, centre weight 1.0, result two cycles after win_valid.
    localparam logic [15:0] WTS [9] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0};

    function automatic logic [15:0] mac_fn(input logic [143:0] win);
        int acc = 0;
        for (int k = 0; k < 9; k++) begin
            acc += int'($signed(win[16*k +: 16])) * int'($signed(WTS[k]));
        end
        return 16'(acc >>> 8);
    endfunction

    logic        mac_v1 = 1'b0, mac_v2 = 1'b0;
    logic [15:0] mac_d1 = '0, mac_d2 = '0;
    logic        inj_valid = 1'b0;
    logic [15:0] inj_data = '0;
    always @(posedge clk) begin
        mac_v1 <= win_valid;
        mac_d1 <= mac_fn(win_data);
        mac_v2 <= mac_v1;
        mac_d2 <= mac_d1;
    end
    assign conv_valid = mac_v2 | inj_valid;
    assign conv_data  = inj_valid ? inj_data : mac_d2;

    // Monitor: everything the DUT does is logged on the falling edge.
    int          cyc = 0;
    int          rd_addr_log[$], rd_cyc_log[$], wr_addr_log[$], wr_data_log[$], win_cyc_log[$];
    logic [143:0] win_log[$];
    int          done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_rd_en) begin
            rd_addr_log.push_back(int'(pix_rd_addr));
            rd_cyc_log.push_back(cyc);
        end
        if (out_wr_en) begin
            wr_addr_log.push_back(int'(out_wr_addr));
            wr_data_log.push_back(int'(out_wr_data));
        end
        if (win_valid) begin
            win_log.push_back(win_data);
            win_cyc_log.push_back(cyc);
        end
        if (done) done_cnt++;
    end

    int total = 0;
    int bad   = 0;
    int rd_base, wr_base, win_base, done_base;
    int busy_low;

    typedef struct {
        int w;
        int h;
        bit err;
        int nwr;
        int nrd;
    } vec_t;
    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] relu_ref(input logic [15:0] v);
`ifdef CONV3X3_SCHED_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic setVec(input int i, input int w, input int h, input bit err, input int nwr, input int nrd);
        vecs[i].w = w; vecs[i].h = h; vecs[i].err = err; vecs[i].nwr = nwr; vecs[i].nrd = nrd;
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 1024; i++) pix_mem[i] = 16'($urandom);
    endtask

    // Runs one frame; poke_at >= 0 pulses start with new cfg that many cycles into the frame.
    task automatic applyStimulus(input int w, input int h, input int poke_at, output bit finished);
        rd_base   = rd_addr_log.size();
        wr_base   = wr_addr_log.size();
        win_base  = win_log.size();
        done_base = done_cnt;
        busy_low  = 0;
        finished  = 1'b0;
        @(negedge clk);
        cfg_width  = DIM_W'(w);
        cfg_height = DIM_W'(h);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (!busy) busy_low++;
            start = (i == poke_at);
            if (i == poke_at) begin
                cfg_width  = 8'd3;
                cfg_height = 8'd3;
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    // Compares the logged frame against the reference built from the pixel memory.
    task automatic checkFrame(input string tag, input int w, input int h, input bit finished,
                              input bit exp_err, input int exp_nwr, input int exp_nrd);
        int n;
        logic [143:0] ew;
        n = exp_nwr;
        checkOutput({tag, "_finished"}, 144'(finished), 144'(1));
        checkOutput({tag, "_cfg_err"}, 144'(cfg_err), 144'(exp_err));
        checkOutput({tag, "_done_pulses"}, 144'(done_cnt - done_base), 144'(1));
        checkOutput({tag, "_busy_low"}, 144'(busy_low), 144'(0));
        checkOutput({tag, "_idle_after"}, 144'({busy, done}), 144'(0));
        checkOutput({tag, "_num_writes"}, 144'(wr_addr_log.size() - wr_base), 144'(exp_nwr));
        checkOutput({tag, "_num_reads"}, 144'(rd_addr_log.size() - rd_base), 144'(exp_nrd));
        checkOutput({tag, "_num_windows"}, 144'(win_log.size() - win_base), 144'(exp_nwr));
        for (int j = 0; j < n; j++) begin
            int r = j / (w - 2);
            int c = j % (w - 2);
            ew = '0;
            for (int k = 0; k < 9; k++) begin
                int a = (r + k / 3) * w + c + k % 3;
                ew[16*k +: 16] = pix_mem[a];
                if (rd_base + 9*j + k < rd_addr_log.size())
                    checkOutput($sformatf("%s_rd_addr[%0d]", tag, 9*j + k),
                                144'(rd_addr_log[rd_base + 9*j + k]), 144'(a));
            end
            if (win_base + j < win_log.size())
                checkOutput($sformatf("%s_window[%0d]", tag, j), win_log[win_base + j], ew);
            if (wr_base + j < wr_addr_log.size()) begin
                checkOutput($sformatf("%s_wr_addr[%0d]", tag, j), 144'(wr_addr_log[wr_base + j]), 144'(j));
                checkOutput($sformatf("%s_wr_data[%0d]", tag, j), 144'(wr_data_log[wr_base + j]),
                            144'(relu_ref(pix_mem[(r + 1) * w + c + 1])));
            end
        end
    endtask

    initial begin
        bit fin;
        int exp_rd [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        logic [15:0] exp_d31 [4] = '{16'h0500, 16'h0600, 16'h0900, 16'h0A00};

        rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        checkOutput("reset_busy", 144'(busy), 144'(0));
        checkOutput("reset_done", 144'(done), 144'(0));
        checkOutput("reset_cfg_err", 144'(cfg_err), 144'(0));
        checkOutput("reset_rd_en", 144'(pix_rd_en), 144'(0));
        checkOutput("reset_win_valid", 144'(win_valid), 144'(0));
        checkOutput("reset_wr_en", 144'(out_wr_en), 144'(0));
        checkOutput("reset_win_data", win_data, 144'(0));

        // 4x4 ramp image: centre pixels 5, 6, 9, 10.
        for (int i = 0; i < 1024; i++) pix_mem[i] = 16'(i * 256);
        applyStimulus(4, 4, -1, fin);
        checkFrame("ramp4x4", 4, 4, fin, 1'b0, 4, 36);
        for (int j = 0; j < 4; j++) begin
            if (wr_base + j < wr_data_log.size())
                checkOutput($sformatf("ramp4x4_const[%0d]", j), 144'(wr_data_log[wr_base + j]), 144'(exp_d31[j]));
        end

        // First window of a 5x3 frame: read order and issue timing.
        fillRandom();
        applyStimulus(5, 3, -1, fin);
        checkFrame("first5x3", 5, 3, fin, 1'b0, 3, 27);
        for (int k = 0; k < 9; k++) begin
            if (rd_base + k < rd_addr_log.size())
                checkOutput($sformatf("first5x3_seq[%0d]", k), 144'(rd_addr_log[rd_base + k]), 144'(exp_rd[k]));
        end
        if (win_base + 1 < win_cyc_log.size() && rd_base + 8 < rd_cyc_log.size()) begin
            checkOutput("first5x3_win_lat", 144'(win_cyc_log[win_base] - rd_cyc_log[rd_base + 8]), 144'(2));
            checkOutput("first5x3_win_period", 144'(win_cyc_log[win_base + 1] - win_cyc_log[win_base]), 144'(12));
        end else begin
            checkOutput("first5x3_win_logged", 144'(0), 144'(1));
        end

        // Table of frame shapes, random image content.
        setVec(0, 4, 4, 1'b0, 4, 36);
        setVec(1, 5, 3, 1'b0, 3, 27);
        setVec(2, 2, 5, 1'b1, 0, 0);
        setVec(3, 3, 3, 1'b0, 1, 9);
        setVec(4, 5, 2, 1'b1, 0, 0);
        setVec(5, 6, 4, 1'b0, 8, 72);
        setVec(6, 8, 8, 1'b0, 36, 324);
        setVec(7, 0, 7, 1'b1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            fillRandom();
            applyStimulus(vecs[i].w, vecs[i].h, -1, fin);
            checkFrame($sformatf("vec%0d", i), vecs[i].w, vecs[i].h, fin, vecs[i].err, vecs[i].nwr, vecs[i].nrd);
        end

        // cfg_err holds after the error frame until reset clears it.
        checkOutput("cfg_err_hold", 144'(cfg_err), 144'(1));
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checkOutput("cfg_err_reset", 144'(cfg_err), 144'(0));

        // Random dimensions, including invalid ones.
        for (int i = 0; i < 4; i++) begin
            int w = $urandom_range(1, 8);
            int h = $urandom_range(1, 8);
            bit e = (w < 3) || (h < 3);
            int n = e ? 0 : (w - 2) * (h - 2);
            fillRandom();
            applyStimulus(w, h, -1, fin);
            checkFrame($sformatf("rand%0d_%0dx%0d", i, w, h), w, h, fin, e, n, 9 * n);
        end

        // start and cfg changes mid-frame are ignored.
        fillRandom();
        applyStimulus(5, 4, 20, fin);
        checkFrame("midstart", 5, 4, fin, 1'b0, 6, 54);

        // Reset during FETCH aborts the frame cleanly.
        fillRandom();
        wr_base = wr_addr_log.size();
        done_base = done_cnt;
        @(negedge clk);
        cfg_width = 8'd6; cfg_height = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_in_fetch", 144'(pix_rd_en), 144'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 144'(busy), 144'(0));
        checkOutput("abort_rd_en", 144'(pix_rd_en), 144'(0));
        checkOutput("abort_win_valid", 144'(win_valid), 144'(0));
        checkOutput("abort_wr_en", 144'(out_wr_en), 144'(0));
        checkOutput("abort_done", 144'(done), 144'(0));
        checkOutput("abort_win_data", win_data, 144'(0));
        inj_valid = 1'b1; inj_data = 16'h1234;
        #1;
        checkOutput("abort_stray_conv", 144'(out_wr_en), 144'(0));
        @(negedge clk);
        inj_valid = 1'b0;
        checkOutput("abort_no_writes", 144'(wr_addr_log.size() - wr_base), 144'(0));
        checkOutput("abort_no_done", 144'(done_cnt - done_base), 144'(0));
        applyStimulus(4, 4, -1, fin);
        checkFrame("after_abort", 4, 4, fin, 1'b0, 4, 36);

        // Negative MAC result through the optional ReLU.
        fillRandom();
        pix_mem[4] = 16'hFF00;
        applyStimulus(3, 3, -1, fin);
        checkFrame("relu3x3", 3, 3, fin, 1'b0, 1, 9);
        if (wr_base < wr_data_log.size()) begin
`ifdef CONV3X3_SCHED_RELU_EN
            checkOutput("relu_neg", 144'(wr_data_log[wr_base]), 144'(16'h0000));
`else
            checkOutput("relu_neg", 144'(wr_data_log[wr_base]), 144'(16'hFF00));
`endif
        end else begin
            checkOutput("relu_logged", 144'(0), 144'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
